// File: rtl/prog_rom.sv
// Program ROM: byte-stream loader fills a word memory, CPU fetches with one-cycle latency while idle.
// Loads assemble bytes little-endian; a short final word is zero-padded.
module prog_rom #(
  parameter int                    DATA_WIDTH = 38,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DEPTH      = 2**ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  busy,
  output logic                  ld_done,
  output logic [ADDR_WIDTH:0]   ld_count
);
  localparam int BPW = (DATA_WIDTH + 7) / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         ld_count_q, ld_count_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [DATA_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  busy_q, ld_ready_q, ld_done_q;
  logic                  we;
  logic [DATA_WIDTH-1:0] asm_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: NOP_WORD};

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    ld_count_d    = ld_count_q;
    byte_d        = byte_q;
    wbuf_d        = wbuf_q;
    we            = 1'b0;
    // Unfilled byte lanes of wbuf are always zero, so OR-ing in the new byte also pads.
    asm_word      = wbuf_q | (DATA_WIDTH'(ld_data) << (8 * int'(byte_q)));
    instr_valid_d = 1'b0;
    instr_d       = instr_q;

    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          ld_count_d = '0;
          byte_d     = '0;
          wbuf_d     = '0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          wr_ptr_d   = '0;
          ld_count_d = '0;
          byte_d     = '0;
          wbuf_d     = '0;
        end else if (ld_valid) begin
          if (byte_q == BW'(BPW - 1) || ld_last) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            ld_count_d = ld_count_q + 1'b1;
            byte_d     = '0;
            wbuf_d     = '0;
            if (ld_last || wr_ptr_d == CW'(DEPTH)) state_d = DONE;
          end else begin
            byte_d = byte_q + 1'b1;
            wbuf_d = asm_word;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && fetch_req) begin
      instr_valid_d = 1'b1;
      instr_d       = ({1'b0, fetch_addr} < CW'(DEPTH)) ? mem[fetch_addr[IW-1:0]] : NOP_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      ld_count_q    <= '0;
      byte_q        <= '0;
      wbuf_q        <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      ld_count_q    <= ld_count_d;
      byte_q        <= byte_d;
      wbuf_q        <= wbuf_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= (state_d != IDLE);
      ld_ready_q    <= (state_d == LOAD);
      ld_done_q     <= (state_d == DONE);
    end
  end

  // Memory has no reset: contents survive rst, only an in-flight write is suppressed.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q[IW-1:0]] <= asm_word;
  end

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign ld_ready    = ld_ready_q;
  assign busy        = busy_q;
  assign ld_done     = ld_done_q;
  assign ld_count    = ld_count_q;
endmodule
